// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-requester device bus arbiter: FSM encoding and requester IDs.
package dev_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    localparam logic ArbM0 = 1'b0;
    localparam logic ArbM1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the requester that did not go last wins a tie, unless a lock
// hold keeps the bus with the previous owner while it still requests.
module rr_pick2
    import dev_bus_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    input  logic i_lock_hold,
    output logic o_winner,
    output logic o_any
);

    logic w_last_req;

    assign w_last_req = (i_last == ArbM1) ? i_req1 : i_req0;
    assign o_any      = i_req0 | i_req1;

    always_comb begin
        if (i_lock_hold && w_last_req) begin
            o_winner = i_last;
        end else if (i_req0 && i_req1) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req1 ? ArbM1 : ArbM0;
        end
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Single device bus shared by CPU bridge (m0) and DMA/debug master (m1), one transaction at a
// time with round-robin fairness and a slave timeout. Define DEV_BUS_ARB_LOCK_EN for bus locking.
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_m0_req,
    input  logic [AW-1:0] i_m0_addr,
    input  logic          i_m0_we,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_done,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic [AW-1:0] i_m1_addr,
    input  logic          i_m1_we,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_done,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_rdata,
`ifdef DEV_BUS_ARB_LOCK_EN
    input  logic          i_m0_lock,
    input  logic          i_m1_lock,
`endif
    output logic          o_s_valid,
    output logic [AW-1:0] o_s_addr,
    output logic          o_s_we,
    output logic [DW-1:0] o_s_wdata,
    input  logic          i_s_ready,
    input  logic [DW-1:0] i_s_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CntOne = CW'(1);

    arb_state_e            r_state, w_state_d;
    logic                  r_last, w_last_d;
    logic                  r_owner, w_owner_d;
    logic [CW-1:0]         r_cnt, w_cnt_d;
    logic                  r_locked, w_locked_d;
    logic                  r_s_valid, w_s_valid_d;
    logic [AW-1:0]         r_s_addr, w_s_addr_d;
    logic                  r_s_we, w_s_we_d;
    logic [DW-1:0]         r_s_wdata, w_s_wdata_d;
    logic [1:0]            r_gnt, w_gnt_d;
    logic [1:0]            r_done, w_done_d;
    logic [1:0]            r_err, w_err_d;
    logic [1:0][DW-1:0]    r_rdata, w_rdata_d;

    logic                  w_winner;
    logic                  w_any;
    logic [1:0]            w_lock;

`ifdef DEV_BUS_ARB_LOCK_EN
    assign w_lock = {i_m1_lock, i_m0_lock};
`else
    assign w_lock = 2'b00;
`endif

    // r_locked only matters in IDLE, where it says the previous owner ended a locked transfer.
    rr_pick2 u_pick (
        .i_req0      (i_m0_req),
        .i_req1      (i_m1_req),
        .i_last      (r_last),
        .i_lock_hold (r_locked),
        .o_winner    (w_winner),
        .o_any       (w_any)
    );

    always_comb begin
        w_state_d   = r_state;
        w_last_d    = r_last;
        w_owner_d   = r_owner;
        w_cnt_d     = r_cnt;
        w_locked_d  = r_locked;
        w_s_valid_d = r_s_valid;
        w_s_addr_d  = r_s_addr;
        w_s_we_d    = r_s_we;
        w_s_wdata_d = r_s_wdata;
        w_gnt_d     = 2'b00;
        w_done_d    = 2'b00;
        w_err_d     = 2'b00;
        w_rdata_d   = r_rdata;

        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_d         = StBusy;
                    w_owner_d         = w_winner;
                    w_cnt_d           = '0;
                    w_s_valid_d       = 1'b1;
                    w_s_addr_d        = (w_winner == ArbM1) ? i_m1_addr : i_m0_addr;
                    w_s_we_d          = (w_winner == ArbM1) ? i_m1_we : i_m0_we;
                    w_s_wdata_d       = (w_winner == ArbM1) ? i_m1_wdata : i_m0_wdata;
                    w_locked_d        = w_lock[w_winner];
                    w_gnt_d[w_winner] = 1'b1;
                end
            end
            StBusy: begin
                // Ready is checked first so a reply in the last allowed cycle still succeeds.
                if (i_s_ready) begin
                    if (!r_s_we) begin
                        w_rdata_d[r_owner] = i_s_rdata;
                    end
                    w_done_d[r_owner] = 1'b1;
                    w_s_valid_d       = 1'b0;
                    w_state_d         = StResp;
                end else if (r_cnt == CntMax) begin
                    w_rdata_d[r_owner] = '0;
                    w_done_d[r_owner]  = 1'b1;
                    w_err_d[r_owner]   = 1'b1;
                    w_locked_d         = 1'b0;
                    w_s_valid_d        = 1'b0;
                    w_state_d          = StResp;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StResp: begin
                w_last_d  = r_owner;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= StIdle;
            r_last    <= ArbM1;
            r_owner   <= ArbM0;
            r_cnt     <= '0;
            r_locked  <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_addr  <= '0;
            r_s_we    <= 1'b0;
            r_s_wdata <= '0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_err     <= 2'b00;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_last    <= w_last_d;
            r_owner   <= w_owner_d;
            r_cnt     <= w_cnt_d;
            r_locked  <= w_locked_d;
            r_s_valid <= w_s_valid_d;
            r_s_addr  <= w_s_addr_d;
            r_s_we    <= w_s_we_d;
            r_s_wdata <= w_s_wdata_d;
            r_gnt     <= w_gnt_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
            r_rdata   <= w_rdata_d;
        end
    end

    assign o_m0_gnt   = r_gnt[0];
    assign o_m0_done  = r_done[0];
    assign o_m0_err   = r_err[0];
    assign o_m0_rdata = r_rdata[0];
    assign o_m1_gnt   = r_gnt[1];
    assign o_m1_done  = r_done[1];
    assign o_m1_err   = r_err[1];
    assign o_m1_rdata = r_rdata[1];
    assign o_s_valid  = r_s_valid;
    assign o_s_addr   = r_s_addr;
    assign o_s_we     = r_s_we;
    assign o_s_wdata  = r_s_wdata;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: directed scenarios plus random traffic against a transaction-level
// schedule model (grant edge, wait count, done cycle). Build with DEV_BUS_ARB_LOCK_EN for locking.
module tb_dev_bus_arbiter;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int          NEVER   = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_done, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_done, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_valid, s_we, s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
`ifdef DEV_BUS_ARB_LOCK_EN
    logic          m0_lock, m1_lock;
`endif

    always #5 clk = ~clk;

    dev_bus_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW), .DW(DW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_m0_req   (m0_req),
        .i_m0_addr  (m0_addr),
        .i_m0_we    (m0_we),
        .i_m0_wdata (m0_wdata),
        .o_m0_gnt   (m0_gnt),
        .o_m0_done  (m0_done),
        .o_m0_err   (m0_err),
        .o_m0_rdata (m0_rdata),
        .i_m1_req   (m1_req),
        .i_m1_addr  (m1_addr),
        .i_m1_we    (m1_we),
        .i_m1_wdata (m1_wdata),
        .o_m1_gnt   (m1_gnt),
        .o_m1_done  (m1_done),
        .o_m1_err   (m1_err),
        .o_m1_rdata (m1_rdata),
`ifdef DEV_BUS_ARB_LOCK_EN
        .i_m0_lock  (m0_lock),
        .i_m1_lock  (m1_lock),
`endif
        .o_s_valid  (s_valid),
        .o_s_addr   (s_addr),
        .o_s_we     (s_we),
        .o_s_wdata  (s_wdata),
        .i_s_ready  (s_ready),
        .i_s_rdata  (s_rdata)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rst_drv  = 1'b0;
    int k_fixed  = -1;
    bit force_en = 1'b0;
    logic [DW-1:0] force_data = '0;

    // Model: a transaction granted at edge g with slave wait k is done at g+k+1 (or g+TIMEOUT).
    bit            m_busy = 1'b0;
    bit            m_owner, m_err, m_was_reset;
    bit            m_last = 1'b1;
    bit            m_hold = 1'b0;
    bit            m_pend_lock = 1'b0;
    int            m_g, m_d, m_k;
    int            m_next = 0;
    txn_t          m_cur;
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] m_ready_data;

    int gnt_log[$];
    int span_log[$];
    int g_seen = 0;
    bit last_err_seen = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                                input logic lk);
        txn_t t;
        t.addr  = a;
        t.we    = we;
        t.wdata = d;
`ifdef DEV_BUS_ARB_LOCK_EN
        t.lock  = lk;
`else
        t.lock  = 1'b0 & lk;
`endif
        return t;
    endfunction

    task automatic model_edge(input int n);
        bit w;
        m_was_reset = 1'b0;
        if (!rst) begin
            m_busy      = 1'b0;
            m_last      = 1'b1;
            m_hold      = 1'b0;
            m_pend_lock = 1'b0;
            m_rdata[0]  = '0;
            m_rdata[1]  = '0;
            m_next      = n + 1;
            m_was_reset = 1'b1;
            return;
        end
        if (m_busy && n == m_d) begin
            if (m_err) m_rdata[m_owner] = '0;
            else if (!m_cur.we) m_rdata[m_owner] = m_ready_data;
            m_last = m_owner;
            m_hold = m_pend_lock && !m_err;
            m_next = m_d + 2;
        end
        if (m_busy && n > m_d) m_busy = 1'b0;
        if (!m_busy && n >= m_next && (m0_req || m1_req)) begin
            if (m_hold && (m_last ? m1_req : m0_req)) w = m_last;
            else if (m0_req && m1_req) w = !m_last;
            else w = m1_req;
            if (w) m_cur = q1.pop_front();
            else   m_cur = q0.pop_front();
            m_owner     = w;
            m_g         = n;
            m_k         = (k_fixed >= 0) ? k_fixed : int'($urandom_range(0, TIMEOUT + 1));
            m_err       = (m_k >= int'(TIMEOUT));
            m_d         = m_g + (m_err ? int'(TIMEOUT) : m_k + 1);
            m_pend_lock = m_cur.lock;
            m_hold      = 1'b0;
            m_busy      = 1'b1;
        end
    endtask

    task automatic check_cycle();
        bit e_sv, e_g, e_d;
        e_sv = m_busy && cyc < m_d;
        e_g  = m_busy && cyc == m_g;
        e_d  = m_busy && cyc == m_d;
        check_val("m0_gnt", 64'(m0_gnt), 64'(e_g && !m_owner));
        check_val("m1_gnt", 64'(m1_gnt), 64'(e_g && m_owner));
        check_val("m0_done", 64'(m0_done), 64'(e_d && !m_owner));
        check_val("m1_done", 64'(m1_done), 64'(e_d && m_owner));
        check_val("s_valid", 64'(s_valid), 64'(e_sv));
        check_val("m0_rdata", 64'(m0_rdata), 64'(m_rdata[0]));
        check_val("m1_rdata", 64'(m1_rdata), 64'(m_rdata[1]));
        if (e_sv) begin
            check_val("s_addr", 64'(s_addr), 64'(m_cur.addr));
            check_val("s_we", 64'(s_we), 64'(m_cur.we));
            check_val("s_wdata", 64'(s_wdata), 64'(m_cur.wdata));
        end
        if (e_d) check_val("err", 64'(m_owner ? m1_err : m0_err), 64'(m_err));
        if (m_was_reset) begin
            check_val("rst_s_addr", 64'(s_addr), 64'h0);
            check_val("rst_s_wdata", 64'(s_wdata), 64'h0);
            check_val("rst_s_we", 64'(s_we), 64'h0);
        end
        if (m0_gnt) begin gnt_log.push_back(0); g_seen = cyc; end
        if (m1_gnt) begin gnt_log.push_back(1); g_seen = cyc; end
        if (m0_done || m1_done) begin
            span_log.push_back(cyc - g_seen);
            last_err_seen = m0_err | m1_err;
        end
    endtask

    task automatic drive_inputs();
        rst = rst_drv;
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_addr = q0[0].addr; m0_we = q0[0].we; m0_wdata = q0[0].wdata;
        end else begin
            m0_req = 1'b0; m0_addr = $urandom; m0_we = 1'($urandom); m0_wdata = $urandom;
        end
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_addr = q1[0].addr; m1_we = q1[0].we; m1_wdata = q1[0].wdata;
        end else begin
            m1_req = 1'b0; m1_addr = $urandom; m1_we = 1'($urandom); m1_wdata = $urandom;
        end
`ifdef DEV_BUS_ARB_LOCK_EN
        m0_lock = (q0.size() > 0) ? q0[0].lock : 1'($urandom);
        m1_lock = (q1.size() > 0) ? q1[0].lock : 1'($urandom);
`endif
        s_rdata = force_en ? force_data : $urandom;
        s_ready = m_busy && !m_err && (cyc == m_g + m_k);
        if (s_ready) m_ready_data = s_rdata;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            model_edge(cyc);
            check_cycle();
            drive_inputs();
        end
    endtask

    task automatic run_until_quiet(input string tag, input int max);
        int i = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !m_busy) && i < max) begin
            run_cycles(1);
            i++;
        end
        check_val({tag, "_quiet"}, 64'(q0.size() == 0 && q1.size() == 0 && !m_busy), 64'h1);
    endtask

    task automatic wait_grant(input string tag, input int max);
        int i = 0;
        while (!m_busy && i < max) begin
            run_cycles(1);
            i++;
        end
        check_val({tag, "_grant"}, 64'(m_busy), 64'h1);
    endtask

    task automatic lock_case(input bit lk, input int exp_second);
        gnt_log.delete();
        k_fixed = 3;
        q1.push_back(mk(32'h0000_4000, 1'b0, '0, lk));
        wait_grant("lock", 20);
        q0.push_back(mk(32'h0000_4100, 1'b0, '0, 1'b0));
        q1.push_back(mk(32'h0000_4200, 1'b0, '0, 1'b0));
        run_until_quiet("lock", 60);
        check_val("lock_cnt", 64'(gnt_log.size()), 64'd3);
        if (gnt_log.size() == 3) begin
            check_val("lock_first", 64'(gnt_log[0]), 64'd1);
            check_val("lock_second", 64'(gnt_log[1]), 64'(exp_second));
            check_val("lock_third", 64'(gnt_log[2]), 64'(1 - exp_second));
        end
    endtask

    initial begin
        drive_inputs();
        run_cycles(2);
        rst_drv = 1'b1;

        // Single m0 read answered in the first BUSY cycle
        k_fixed = 0; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
        q0.push_back(mk(32'h0000_7F00, 1'b0, '0, 1'b0));
        run_until_quiet("single", 20);
        check_val("single_rdata", 64'(m0_rdata), 64'hDEAD_BEEF);
        check_val("single_m1_rdata", 64'(m1_rdata), 64'h0);
        force_en = 1'b0;

        // Both requesters from reset, three writes each, two wait cycles
        rst = 1'b0;
        run_cycles(1);
        gnt_log.delete(); span_log.delete();
        k_fixed = 2;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(32'h0000_1000 + 32'(i), 1'b1, 32'hA000_0000 + 32'(i), 1'b0));
            q1.push_back(mk(32'h0000_2000 + 32'(i), 1'b1, 32'hB000_0000 + 32'(i), 1'b0));
        end
        run_until_quiet("rr", 100);
        check_val("rr_cnt", 64'(gnt_log.size()), 64'd6);
        if (gnt_log.size() == 6) begin
            foreach (gnt_log[i]) check_val("rr_order", 64'(gnt_log[i]), 64'(i % 2));
        end
        foreach (span_log[i]) check_val("rr_span", 64'(span_log[i]), 64'd3);

        // m1 timeout, then a normal m1 transaction
        span_log.delete();
        k_fixed = NEVER;
        q1.push_back(mk(32'h0000_3000, 1'b0, '0, 1'b0));
        run_until_quiet("tmo", 40);
        check_val("tmo_cnt", 64'(span_log.size()), 64'd1);
        if (span_log.size() > 0) check_val("tmo_span", 64'(span_log[0]), 64'(TIMEOUT));
        check_val("tmo_err", 64'(last_err_seen), 64'h1);
        check_val("tmo_rdata", 64'(m1_rdata), 64'h0);
        span_log.delete();
        k_fixed = 1;
        q1.push_back(mk(32'h0000_3004, 1'b0, '0, 1'b0));
        run_until_quiet("after_tmo", 20);
        if (span_log.size() > 0) check_val("after_tmo_span", 64'(span_log[0]), 64'd2);
        check_val("after_tmo_err", 64'(last_err_seen), 64'h0);

        // Slave answers in the very last allowed BUSY cycle
        span_log.delete();
        k_fixed = TIMEOUT - 1; force_en = 1'b1; force_data = 32'h1234_5678;
        q0.push_back(mk(32'h0000_5000, 1'b0, '0, 1'b0));
        run_until_quiet("edge", 40);
        if (span_log.size() > 0) check_val("edge_span", 64'(span_log[0]), 64'(TIMEOUT));
        check_val("edge_err", 64'(last_err_seen), 64'h0);
        check_val("edge_rdata", 64'(m0_rdata), 64'h1234_5678);
        force_en = 1'b0;

        // Reset on the third wait cycle of an m0 transaction
        k_fixed = NEVER;
        q0.push_back(mk(32'h0000_6000, 1'b0, '0, 1'b0));
        begin
            int i = 0;
            while (!(m_busy && cyc == m_g + 2) && i < 40) begin
                run_cycles(1);
                i++;
            end
        end
        rst = 1'b0;
        run_cycles(1);
        check_val("rst_s_valid", 64'(s_valid), 64'h0);
        check_val("rst_m0_done", 64'(m0_done), 64'h0);
        run_cycles(3);
        gnt_log.delete();
        k_fixed = 0;
        q0.push_back(mk(32'h0000_6100, 1'b0, '0, 1'b0));
        q1.push_back(mk(32'h0000_6200, 1'b0, '0, 1'b0));
        run_until_quiet("post_rst", 30);
        if (gnt_log.size() > 0) check_val("post_rst_tie", 64'(gnt_log[0]), 64'd0);

        lock_case(1'b0, 0);
`ifdef DEV_BUS_ARB_LOCK_EN
        lock_case(1'b1, 1);
`endif

        // Random traffic
        k_fixed = -1;
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 3) == 0)
                q0.push_back(mk($urandom, 1'($urandom), $urandom, 1'($urandom)));
            if (q1.size() < 2 && $urandom_range(0, 3) == 0)
                q1.push_back(mk($urandom, 1'($urandom), $urandom, 1'($urandom)));
            if ($urandom_range(0, 399) == 0) rst = 1'b0;
            run_cycles(1);
        end
        run_until_quiet("rand", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
